// File: rtl/sparse_cnn_pkg.sv
// sparse_cnn_pkg: shared lane geometry, drain states and lane slice helper
package sparse_cnn_pkg;
  localparam int NUM_LANES = 128;
  localparam int RES_W = 18;
  localparam int IDX_W = 7;
  typedef enum logic {IDLE, DRAIN} drain_state_e;
  function automatic logic [RES_W-1:0] lane_slice(input logic [NUM_LANES*RES_W-1:0] word, input logic [IDX_W-1:0] idx);
    return word[idx*RES_W +: RES_W];
  endfunction
endpackage

// File: rtl/sparse_prio_enc.sv
// sparse_prio_enc: lowest-set-bit encoder with any and single-bit-remaining flags
module sparse_prio_enc #(
  parameter int N = 128,
  parameter int IW = 7
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          one
);
  localparam logic [N-1:0] ONE_V = 1;
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = vec[i] ? IW'(i) : idx;
  end
  assign any = |vec;
  assign one = any && ((vec & (vec - ONE_V)) == '0);
endmodule

// File: rtl/sparse_result_drain.sv
// sparse_result_drain: snapshots the 128-lane result word and streams valid lanes in ascending order
module sparse_result_drain
  import sparse_cnn_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_async,
  input  logic [NUM_LANES*RES_W-1:0] result_buffer,
  input  logic [NUM_LANES-1:0]       valid_buffer,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RES_W-1:0]           out_data,
  output logic [IDX_W-1:0]           out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic [CNT_W-1:0]           drop_count
);
  localparam logic [NUM_LANES-1:0] LANE_ONE = 1;
  drain_state_e state_q, state_d;
  logic [NUM_LANES-1:0] pend_q, pend_d;
  logic [NUM_LANES*RES_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [IDX_W-1:0] idx;
  logic any, one, acc, cap;
  sparse_prio_enc #(.N(NUM_LANES), .IW(IDX_W)) u_enc (
    .vec(pend_q),
    .idx(idx),
    .any(any),
    .one(one)
  );
  assign busy = state_q == DRAIN;
  assign out_valid = busy && any;
  assign out_index = out_valid ? idx : '0;
  assign out_data = out_valid ? lane_slice(snap_q, idx) : '0;
  assign out_last = out_valid && one;
  assign acc = out_valid && out_ready;
  // a new word is taken when idle or on the edge that retires the final beat
  assign cap = |valid_buffer && (!busy || (acc && one));
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    snap_d = snap_q;
    drop_d = drop_q;
    if (cap) begin
      state_d = DRAIN;
      pend_d = valid_buffer;
      snap_d = result_buffer;
    end else if (busy) begin
      pend_d = acc ? pend_q & ~(LANE_ONE << idx) : pend_q;
      state_d = (acc && one) ? IDLE : DRAIN;
      drop_d = (|valid_buffer && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset_async) begin
      state_q <= IDLE;
      pend_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk) snap_q <= snap_d;
  assign drop_count = drop_q;
endmodule

// File: doc/sparse_result_drain.md
Name: sparse_result_drain

Overview:
Consumer-side reader for the accelerator's parallel result interface (result_buffer / valid_buffer).
- When any lane flags valid, it snapshots the full 128-lane result word.
- It then streams only the valid lanes, lowest index first, one beat per cycle, over a valid/ready handshake.
- It sits between sparse_cnn_accelerator_top and the output writeback/DMA path, and replaces bench-side bulk $display inspection with a compacted sparse stream.

Parameters:
NUM_LANES, 128, number of result lanes (width of valid_buffer)
RES_W, 18, bits per lane result; result_buffer width = NUM_LANES*RES_W
IDX_W, 7, lane index width = clog2(NUM_LANES)
CNT_W, 16, width of saturating drop counter

Ports:
clk  input  1  single clock, rising-edge
reset_async  input  1  synchronous, active-high reset (sampled only on clk rising edge despite the name)
result_buffer  input  NUM_LANES*RES_W  lane i occupies bits [i*RES_W +: RES_W]
valid_buffer  input  NUM_LANES  per-lane result valid from accelerator
out_valid  output  1  beat available
out_ready  input  1  downstream accepts beat
out_data  output  RES_W  lane result, passed through unmodified
out_index  output  IDX_W  lane index of out_data
out_last  output  1  high on the final beat of a snapshot
busy  output  1  high while a snapshot is pending (DRAIN state)
drop_count  output  CNT_W  saturating count of snapshots discarded while busy

Behaviour:
- Reset (reset_async=1 at a clk edge), including mid-drain:
  - state=IDLE; pending mask cleared; snapshot data don't-care.
  - out_valid=0, out_last=0, busy=0, drop_count=0.
  - out_data and out_index read 0 while out_valid=0.
- IDLE:
  - If |valid_buffer at edge N, capture result_buffer into the snapshot and valid_buffer into the pending mask; go to DRAIN.
  - out_valid=1 from cycle N+1, so capture latency is one cycle.
  - If valid_buffer==0, remain in IDLE.
- DRAIN:
  - out_valid=busy=1.
  - out_index = lowest set bit of pending; out_data = snapshot lane[out_index].
  - out_last=1 iff exactly one pending bit remains.
  - out_data, out_index and out_last are combinational from registered state and must stay stable while out_valid && !out_ready.
- Accept (out_valid && out_ready at an edge): clear pending[out_index].
  - Not last: stay in DRAIN and present the next lowest set lane on the next cycle. Throughput is one beat per cycle.
  - Last, valid_buffer==0: go to IDLE.
  - Last, valid_buffer!=0 on the same edge: capture the new snapshot directly and stay in DRAIN. This is a back-to-back capture with no bubble and no drop.
- Overflow: |valid_buffer in DRAIN, except the last-accept edge above.
  - The new data is discarded; the snapshot is untouched.
  - drop_count increments by 1, saturating at 2^CNT_W-1.
  - One increment per cycle in which valid_buffer is nonzero.
- valid_buffer is sampled only on edges; no edge detection. A level held for k cycles while DRAIN counts k drops.
- out_ready while out_valid=0 is ignored.
- Lane order: strictly ascending index within a snapshot. Each set bit produces exactly one beat; zero-valid lanes produce no beat.
- No arithmetic is performed on results; sign and width are preserved bit-exact.

Decomposition:
- Shared package sparse_cnn_pkg:
  - NUM_LANES, RES_W, IDX_W constants, matching the accelerator top.
  - drain state enum {IDLE, DRAIN}.
  - Lane slice helper function.
- One sub-module, sparse_prio_enc: parameterised lowest-set-bit encoder. It outputs index, any, and onehot-remaining (count==1) flags.
- Everything else (snapshot, FSM, counter) lives in sparse_result_drain.

Test Plan:
1. Reset, then valid_buffer=128'h5 with lane0=18'd5, lane2=18'd30 for one cycle, out_ready=1 -> beats (idx0,5,last=0) then (idx2,30,last=1); busy low on the following cycle.
2. Backpressure: same input, out_ready=0 for 3 cycles after out_valid rises -> out_index=0, out_data=5 held 3 cycles; beats complete once out_ready=1; drop_count=0.
3. Single lane at boundary: valid_buffer bit127 only, lane127=18'h3FFFF -> one beat idx127, data 18'h3FFFF, last=1; all-ones valid_buffer -> 128 beats, indices 0..127, last only on 127.
4. Overflow: during a 4-beat drain, pulse valid_buffer=128'h1 for 2 cycles mid-drain -> drop_count=2; original 4 beats emitted unchanged; returns to IDLE.
5. Back-to-back: assert valid_buffer=128'h8 (lane3=18'd7) on the edge the last beat is accepted -> no IDLE cycle; next beat is (idx3,7,last=1); drop_count unchanged.
6. Reset mid-drain after 1 of 3 beats -> next cycle out_valid=0, busy=0, drop_count=0; a subsequent snapshot drains normally from its lowest lane.
